hc_encode_stream: RTL

//  Streaming Hamming(7,4) encoder sitting directly upstream of hc_decode.
//  - Accepts 4-bit data words on a valid/ready handshake.
//  - Computes the 7-bit codeword and buffers it in a small FIFO.
//  - Presents codewords on a valid/ready output whose o_enc_data feeds
//    hc_decode.i_enc_data (bit positions 7..1, parity at positions 1, 2 and 4).

---
 rtl/hc_encode_stream.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/hc_encode_stream.sv
// ---------------------------------------------------------------------------
// hc_encode_stream
//
// Streaming Hamming(7,4) encoder. It accepts 4-bit data words on a
// valid/ready handshake, encodes each word into a 7-bit codeword, and buffers
// the codewords in a small FIFO. The FIFO head is presented on a valid/ready
// output that drives hc_decode.i_enc_data directly. Parity bits sit at
// codeword positions 1, 2 and 4.
//
// Ports
//   i_clk        clock, rising edge
//   i_rst_n      asynchronous active-low reset
//   i_valid      i_data valid
//   o_ready      encoder can accept a word (FIFO not full, out of reset)
//   i_data       data nibble [4:1]
//   o_valid      o_enc_data valid (FIFO not empty)
//   i_ready      downstream accepts o_enc_data
//   o_enc_data   codeword at the FIFO head [7:1] (0 while empty)
//   o_word_cnt   number of words accepted since reset, wraps
//   o_level      FIFO occupancy
//   i_inj_en     (HC_ERR_INJ_EN only) inject an error into this word
//   i_inj_pos    (HC_ERR_INJ_EN only) codeword bit to invert, 0 = none
//
// Configuration macro
//   HC_ERR_INJ_EN  when defined, adds the error-injection ports. The stored
//                  codeword has bit [i_inj_pos] inverted after parity has
//                  been computed. When undefined, codewords are always clean.
// ---------------------------------------------------------------------------
module hc_encode_stream #(
    parameter int FIFO_DEPTH = 4,   // power of 2, >= 2
    parameter int CNT_W      = 16
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_valid,
    output logic                        o_ready,
    input  logic [4:1]                  i_data,
    output logic                        o_valid,
    input  logic                        i_ready,
    output logic [7:1]                  o_enc_data,
    output logic [CNT_W-1:0]            o_word_cnt,
    output logic [$clog2(FIFO_DEPTH):0] o_level
`ifdef HC_ERR_INJ_EN
    ,
    input  logic                        i_inj_en,
    input  logic [2:0]                  i_inj_pos
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

    // Codeword layout {c7,c6,c5,c4,c3,c2,c1}: data occupies positions 3,5,6,7.
    function automatic logic [7:1] hamming_encode(input logic [4:1] d);
        logic c1, c2, c3, c4, c5, c6, c7;
        c3 = d[1];
        c5 = d[2];
        c6 = d[3];
        c7 = d[4];
        c1 = c3 ^ c5 ^ c7;
        c2 = c3 ^ c6 ^ c7;
        c4 = c5 ^ c6 ^ c7;
        return {c7, c6, c5, c4, c3, c2, c1};
    endfunction

    logic [7:1]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             run_q;   // low in reset, high from the first edge after release
    logic             push;
    logic             pop;
    logic [7:1]       wr_code;

    // Handshake flags depend on registered state only, so there is no
    // combinational path from i_valid or i_ready to o_ready.
    assign o_valid = (level_q != '0);
    assign o_ready = run_q && (level_q != LVL_FULL);
    assign push    = i_valid && o_ready;
    assign pop     = o_valid && i_ready;

    // Force zero while empty so the output is clean during and after reset.
    assign o_enc_data = o_valid ? mem_q[rd_ptr_q] : '0;
    assign o_level    = level_q;
    assign o_word_cnt = cnt_q;

    // Codeword to store: parity first, then the optional injected flip.
    always_comb begin
        // NOTE: every variable assigned in always_comb gets a default first,
        // so no path leaves it unassigned and no latch is inferred.
        wr_code = hamming_encode(i_data);
`ifdef HC_ERR_INJ_EN
        if (i_inj_en && (i_inj_pos != 3'd0)) begin
            wr_code[i_inj_pos] = ~wr_code[i_inj_pos];
        end
`endif
    end

    // Next-state logic for the pointers, occupancy and word counter.
    // Pointers wrap naturally because FIFO_DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        cnt_d    = cnt_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
            cnt_d    = cnt_q + CNT_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        unique case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;   // idle, or push and pop together
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            cnt_q    <= '0;
            run_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            cnt_q    <= cnt_d;
            run_q    <= 1'b1;
        end
    end

    // NOTE: the storage array has no reset; an entry is only observed after
    // it has been written, and o_enc_data is masked to zero while empty.
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_code;
        end
    end

endmodule
